// File: rtl/execute_control_pipe.sv
// Execute-stage control decoder: registered decode outputs with valid/ready handshake and MUL/DIV latency sequencing.
// Build option: define SIGN_EXT_IMM_EN to sign-extend the I-type immediate (zero-extended otherwise).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | issue open, output register follows accept/drain
// S_MD_BUSY | MUL/DIV countdown running, issue stalled, out_valid low
module execute_control_pipe #(
   parameter int DATA_W     = 32,
   parameter int IMM_W      = 17,
   parameter int JIMM_W     = 27,
   parameter int MUL_CYCLES = 4,
   parameter int DIV_CYCLES = 32
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       instruction,
   input  logic [DATA_W-1:0] pc,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [4:0]        alu_opcode,
   output logic [4:0]        ctrl_shamt,
   output logic [DATA_W-1:0] immediate_value,
   output logic [DATA_W-1:0] jump_immediate_value,
   output logic              i_signal,
   output logic              j_signal,
   output logic              jr_signal,
   output logic              md_start,
   output logic              md_busy
);

   localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC);

   typedef enum logic {S_IDLE, S_MD_BUSY} state_t;

   state_t              r_state, w_state_nxt;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_out_valid;
   logic [4:0]          r_alu_op, r_shamt;
   logic [DATA_W-1:0]   r_imm, r_jimm;
   logic                r_i, r_j, r_jr;

   logic [4:0]          w_opcode;
   logic [4:0]          w_alu_op;
   logic                w_i, w_j, w_jr;
   logic                w_is_mul, w_is_div, w_is_md;
   logic                w_accept;
   logic                w_md_done;
   logic [DATA_W-1:0]   w_imm, w_jimm;
   logic                w_unused_pc;

   assign w_opcode  = instruction[31:27];
   assign w_is_mul  = (w_opcode == 5'b00000) && (instruction[6:2] == 5'b00110);
   assign w_is_div  = (w_opcode == 5'b00000) && (instruction[6:2] == 5'b00111);
   assign w_is_md   = w_is_mul | w_is_div;
   assign w_accept  = in_valid & in_ready;
   assign w_md_done = (r_state == S_MD_BUSY) && (r_cnt == CNT_W'(1));

`ifdef SIGN_EXT_IMM_EN
   assign w_imm = {{(DATA_W-IMM_W){instruction[IMM_W-1]}}, instruction[IMM_W-1:0]};
`else
   assign w_imm = {{(DATA_W-IMM_W){1'b0}}, instruction[IMM_W-1:0]};
`endif
   assign w_jimm      = {pc[DATA_W-1:JIMM_W], instruction[JIMM_W-1:0]};
   assign w_unused_pc = ^pc[JIMM_W-1:0];

   always_comb begin
      w_alu_op = instruction[6:2];
      w_i      = 1'b0;
      w_j      = 1'b0;
      w_jr     = 1'b0;
      case (w_opcode)
         5'b00101, 5'b00111, 5'b01000: begin w_alu_op = 5'b00000; w_i = 1'b1; end
         5'b00010, 5'b00110:           begin w_alu_op = 5'b00001; w_j = 1'b1; end
         5'b00001, 5'b00011:           w_j = 1'b1;
         5'b00100:                     begin w_j = 1'b1; w_jr = 1'b1; end
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:    if (w_accept && w_is_md) w_state_nxt = S_MD_BUSY;
         S_MD_BUSY: if (w_md_done)           w_state_nxt = S_IDLE;
         default:   w_state_nxt = S_IDLE;
      endcase
      if (flush) w_state_nxt = S_IDLE;
   end

   always_comb begin
      in_ready = (r_state == S_IDLE) & (~r_out_valid | out_ready) & ~flush;
      md_busy  = (r_state == S_MD_BUSY);
      md_start = w_accept & w_is_md;
   end

   // Counter holds at zero once the countdown ends; it never wraps.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)                              r_cnt <= '0;
      else if (flush)                           r_cnt <= '0;
      else if (w_accept && w_is_mul)            r_cnt <= CNT_W'(MUL_CYCLES - 1);
      else if (w_accept && w_is_div)            r_cnt <= CNT_W'(DIV_CYCLES - 1);
      else if (md_busy && r_cnt != '0)          r_cnt <= r_cnt - CNT_W'(1);
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)        r_out_valid <= 1'b0;
      else if (flush)     r_out_valid <= 1'b0;
      else if (w_md_done) r_out_valid <= 1'b1;
      else if (w_accept)  r_out_valid <= ~w_is_md;
      else if (out_ready) r_out_valid <= 1'b0;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_alu_op <= '0;
         r_shamt  <= '0;
         r_imm    <= '0;
         r_jimm   <= '0;
         r_i      <= 1'b0;
         r_j      <= 1'b0;
         r_jr     <= 1'b0;
      end else if (w_accept) begin
         r_alu_op <= w_alu_op;
         r_shamt  <= instruction[11:7];
         r_imm    <= w_imm;
         r_jimm   <= w_jimm;
         r_i      <= w_i;
         r_j      <= w_j;
         r_jr     <= w_jr;
      end
   end

   assign out_valid            = r_out_valid;
   assign alu_opcode           = r_alu_op;
   assign ctrl_shamt           = r_shamt;
   assign immediate_value      = r_imm;
   assign jump_immediate_value = r_jimm;
   assign i_signal             = r_i;
   assign j_signal             = r_j;
   assign jr_signal            = r_jr;

endmodule

// File: tb/tb_execute_control_pipe.sv
// Scoreboard bench for execute_control_pipe: directed cases then randomized traffic against a cycle-level model.
module tb_execute_control_pipe;

   localparam int DATA_W     = 32;
   localparam int IMM_W      = 17;
   localparam int JIMM_W     = 27;
   localparam int MUL_CYCLES = 4;
   localparam int DIV_CYCLES = 32;

   logic              clock = 1'b0;
   logic              resetn = 1'b0;
   logic              in_valid = 1'b0;
   logic              flush = 1'b0;
   logic              out_ready = 1'b0;
   logic [31:0]       instruction = '0;
   logic [DATA_W-1:0] pc = '0;
   logic              in_ready, out_valid, i_signal, j_signal, jr_signal, md_start, md_busy;
   logic [4:0]        alu_opcode, ctrl_shamt;
   logic [DATA_W-1:0] immediate_value, jump_immediate_value;

   execute_control_pipe #(
      .DATA_W(DATA_W), .IMM_W(IMM_W), .JIMM_W(JIMM_W),
      .MUL_CYCLES(MUL_CYCLES), .DIV_CYCLES(DIV_CYCLES)
   ) dut (
      .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
      .instruction(instruction), .pc(pc), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .alu_opcode(alu_opcode), .ctrl_shamt(ctrl_shamt),
      .immediate_value(immediate_value), .jump_immediate_value(jump_immediate_value),
      .i_signal(i_signal), .j_signal(j_signal), .jr_signal(jr_signal),
      .md_start(md_start), .md_busy(md_busy)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [4:0]        alu;
      logic [4:0]        shamt;
      logic [DATA_W-1:0] imm;
      logic [DATA_W-1:0] jimm;
      logic              i_s, j_s, jr_s;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   pend  = -1;   // cycle at which the in-flight MUL/DIV result must appear, -1 if none
   bit   ov    = 1'b0; // output register expected valid this cycle

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic exp_t model(input logic [31:0] ins, input logic [DATA_W-1:0] p);
      exp_t       e;
      logic [4:0] op;
      op     = ins[31:27];
      e.alu  = ins[6:2];
      e.shamt = ins[11:7];
      e.i_s  = 1'b0;
      e.j_s  = 1'b0;
      e.jr_s = 1'b0;
      e.imm  = DATA_W'(ins[IMM_W-1:0]);
`ifdef SIGN_EXT_IMM_EN
      if (ins[IMM_W-1]) e.imm = e.imm | ~((DATA_W'(1) << IMM_W) - DATA_W'(1));
`endif
      e.jimm = ((p >> JIMM_W) << JIMM_W) | DATA_W'(ins[JIMM_W-1:0]);
      case (op)
         5'd5, 5'd7, 5'd8: begin e.alu = 5'd0; e.i_s = 1'b1; end
         5'd2, 5'd6:       begin e.alu = 5'd1; e.j_s = 1'b1; end
         5'd1, 5'd3:       e.j_s = 1'b1;
         5'd4:             begin e.j_s = 1'b1; e.jr_s = 1'b1; end
         default: ;
      endcase
      return e;
   endfunction

   // One clock cycle of stimulus; control outputs checked against the model every cycle.
   task automatic step(input bit v, input logic [31:0] ins, input logic [DATA_W-1:0] p,
                       input bit ordy, input bit fl);
      bit exp_rdy, acc, is_mul, is_div;
      @(posedge clock);
      #1;
      in_valid = v; instruction = ins; pc = p; out_ready = ordy; flush = fl;
      @(negedge clock);
      exp_rdy = (pend < 0) && (!ov || ordy) && !fl;
      acc     = v && exp_rdy;
      is_mul  = (ins[31:27] == 5'd0) && (ins[6:2] == 5'd6);
      is_div  = (ins[31:27] == 5'd0) && (ins[6:2] == 5'd7);
      chk("in_ready",  64'(in_ready),  64'(exp_rdy));
      chk("out_valid", 64'(out_valid), 64'(ov));
      chk("md_busy",   64'(md_busy),   64'(pend >= 0));
      chk("md_start",  64'(md_start),  64'(acc && (is_mul || is_div)));
      if (fl) begin
         ov = 1'b0; pend = -1; sb_q.delete();
      end else if (pend >= 0 && cyc + 1 == pend) begin
         ov = 1'b1; pend = -1;
      end else if (acc) begin
         sb_q.push_back(model(ins, p));
         if (is_mul)      begin pend = cyc + MUL_CYCLES; ov = 1'b0; end
         else if (is_div) begin pend = cyc + DIV_CYCLES; ov = 1'b0; end
         else             ov = 1'b1;
      end else if (ordy) begin
         ov = 1'b0;
      end
      cyc++;
   endtask

   task automatic reset_check(input string tag);
      chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      chk({tag, "_md_busy"},   64'(md_busy),   64'd0);
      chk({tag, "_md_start"},  64'(md_start),  64'd0);
      chk({tag, "_in_ready"},  64'(in_ready),  64'd1);
      chk({tag, "_fields"},
          64'({alu_opcode, ctrl_shamt, i_signal, j_signal, jr_signal}), 64'd0);
      chk({tag, "_imm"},  64'(immediate_value),      64'd0);
      chk({tag, "_jimm"}, 64'(jump_immediate_value), 64'd0);
   endtask

   task automatic async_reset();
      @(posedge clock);
      #3;
      resetn = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
      #1;
      reset_check("midrst");
      ov = 1'b0; pend = -1; sb_q.delete();
      repeat (2) @(posedge clock);
      #1 resetn = 1'b1;
   endtask

   function automatic logic [31:0] rand_ins();
      logic [31:0] ins;
      int          r;
      ins = $urandom;
      r   = $urandom_range(0, 11);
      case (r)
         0: ins[31:27] = 5'd5;  1: ins[31:27] = 5'd7;  2: ins[31:27] = 5'd8;
         3: ins[31:27] = 5'd2;  4: ins[31:27] = 5'd6;  5: ins[31:27] = 5'd1;
         6: ins[31:27] = 5'd3;  7: ins[31:27] = 5'd4;
         8: begin ins[31:27] = 5'd0; ins[6:2] = 5'd6; end
         9: begin ins[31:27] = 5'd0; ins[6:2] = ($urandom_range(0, 2) == 0) ? 5'd7 : 5'd6; end
         default: ;
      endcase
      return ins;
   endfunction

   // Monitor: consumes one scoreboard entry per output handshake.
   initial begin
      forever begin
         @(negedge clock);
         if (resetn && out_valid && out_ready && !flush) begin
            if (sb_q.size() == 0) begin
               total++; bad++;
               $display("FAIL sb_empty: out_valid with no expected entry (cycle %0d)", cyc);
            end else begin
               mon_e = sb_q.pop_front();
               chk("alu_opcode", 64'(alu_opcode),           64'(mon_e.alu));
               chk("ctrl_shamt", 64'(ctrl_shamt),           64'(mon_e.shamt));
               chk("imm",        64'(immediate_value),      64'(mon_e.imm));
               chk("jimm",       64'(jump_immediate_value), 64'(mon_e.jimm));
               chk("i_signal",   64'(i_signal),             64'(mon_e.i_s));
               chk("j_signal",   64'(j_signal),             64'(mon_e.j_s));
               chk("jr_signal",  64'(jr_signal),            64'(mon_e.jr_s));
            end
         end
      end
   end

   initial begin
      #2;
      reset_check("rst");
      #20 resetn = 1'b1;

      step(1, 32'h2801FFFF, 32'h0, 1, 0);
      step(1, 32'h10000000, 32'h0, 1, 0);
      step(1, 32'h08000123, 32'hF8000000, 1, 0);
      step(1, 32'h20000000, 32'h0, 1, 0);
      step(0, 32'h0, 32'h0, 1, 0);

      step(1, 32'h00000018, 32'h0, 1, 0);
      repeat (5) step(1, 32'h2800000A, 32'h0, 1, 0);
      step(0, 32'h0, 32'h0, 1, 0);

      step(1, 32'h0000001C, 32'h0, 1, 0);
      repeat (33) step(0, 32'h0, 32'h0, 1, 0);

      step(1, 32'h40000005, 32'h0, 0, 0);
      repeat (3) step(1, 32'h10000040, 32'h0, 0, 0);
      step(1, 32'h10000040, 32'h0, 1, 0);
      step(0, 32'h0, 32'h0, 1, 0);

      step(1, 32'h00000018, 32'h0, 1, 0);
      step(0, 32'h0, 32'h0, 1, 0);
      step(1, 32'h28000001, 32'h0, 1, 1);
      repeat (5) step(0, 32'h0, 32'h0, 1, 0);

      step(1, 32'h2800FFFF, 32'h0, 0, 0);
      step(0, 32'h0, 32'h0, 0, 1);
      step(0, 32'h0, 32'h0, 1, 0);

      step(1, 32'h0000001C, 32'h0, 1, 0);
      repeat (5) step(0, 32'h0, 32'h0, 1, 0);
      async_reset();
      repeat (40) step(0, 32'h0, 32'h0, 1, 0);

      for (int i = 0; i < 1500; i++)
         step($urandom_range(0, 3) != 0, rand_ins(), $urandom,
              $urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0);
      repeat (DIV_CYCLES + 2) step(0, 32'h0, 32'h0, 1, 0);

      total++;
      if (sb_q.size() != 0) begin
         bad++;
         $display("FAIL sb_leftover: got %0d entries expected 0", sb_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
